// File: rtl/sisc_core_mc.sv
// Multi-cycle SISC execution core: register file, ALU, status register and a
// four-state control FSM (IDLE/DEC/EXE/WB) plus a HALT sink.
module sisc_core_mc #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic [31:0]       instr,
  input  logic              instr_vld,
  output logic              instr_rdy,
  output logic              done,
  output logic              halted,
  output logic              illegal,
  output logic [3:0]        stat,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int         SW   = $clog2(DATA_W);
  localparam int         MSB  = DATA_W - 1;
  localparam logic [4:0] NREG = 5'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEC,
    S_EXE,
    S_WB,
    S_HALT
  } state_t;

  state_t              state;
  logic [31:0]         instr_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   res_q;
  logic [3:0]          flg_q;
  logic [DATA_W-1:0]   rf [16];

  logic [3:0]          op;
  logic [3:0]          fn;
  logic [3:0]          rd;
  logic [3:0]          rs;
  logic [3:0]          rt;
  logic [DATA_W-1:0]   imm_ext;
  logic                is_alu;
  logic                fn_ok;
  logic                op_ok;
  logic                wb_legal;
  logic                bad_instr;

  assign op        = instr_q[31:28];
  assign fn        = instr_q[27:24];
  assign rd        = instr_q[23:20];
  assign rs        = instr_q[19:16];
  assign rt        = instr_q[15:12];
  assign imm_ext   = DATA_W'($signed(instr_q[15:0]));
  assign is_alu    = (op == 4'd1) || (op == 4'd2);
  assign fn_ok     = (fn <= 4'd9);
  assign op_ok     = is_alu || (op == 4'd0) || (op == 4'hF);
  assign wb_legal  = is_alu && fn_ok;
  assign bad_instr = !op_ok || (is_alu && !fn_ok);

  // R0 and indices beyond the implemented register count always read as zero.
  function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] idx);
    if (idx != 4'd0 && {1'b0, idx} < NREG) return rf[idx];
    return '0;
  endfunction

  assign dbg_data  = rf_read(dbg_addr);
  assign instr_rdy = (state == S_IDLE) && !rst_f;
  assign halted    = (state == S_HALT);

  logic [SW-1:0]         sh;
  logic [SW-1:0]         rot;
  logic [DATA_W:0]       wide;
  logic [2*DATA_W-1:0]   dbl;
  logic [DATA_W-1:0]     alu_res;
  logic                  alu_c;
  logic                  alu_v;

  assign sh  = b_q[SW-1:0];
  assign rot = SW'(32'(sh) % DATA_W);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    wide    = '0;
    dbl     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (fn)
      4'd0: begin
        wide    = {1'b0, a_q} + {1'b0, b_q};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
        alu_v   = (a_q[MSB] == b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      4'd1: begin
        alu_res = a_q - b_q;
        alu_c   = (a_q >= b_q);
        alu_v   = (a_q[MSB] != b_q[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      4'd2: alu_res = a_q & b_q;
      4'd3: alu_res = a_q | b_q;
      4'd4: alu_res = a_q ^ b_q;
      4'd5: alu_res = ~a_q;
      4'd6: begin
        // The extra top bit catches the last bit pushed out of the word.
        wide    = {1'b0, a_q} << sh;
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      4'd7: begin
        wide    = {a_q, 1'b0} >> sh;
        alu_res = wide[DATA_W:1];
        alu_c   = wide[0];
      end
      4'd8: begin
        dbl     = {a_q, a_q} << rot;
        alu_res = dbl[2*DATA_W-1:DATA_W];
      end
      4'd9: begin
        dbl     = {a_q, a_q} >> rot;
        alu_res = dbl[DATA_W-1:0];
      end
      default: alu_res = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state   <= S_IDLE;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
      stat    <= '0;
      // NOTE: the register file is architecturally cleared by reset, so it is reset here
      // even though that rules out a RAM macro.
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_vld) begin
            instr_q <= instr;
            state   <= S_DEC;
          end
        end
        S_DEC: begin
          a_q   <= rf_read(rs);
          b_q   <= (op == 4'd2) ? imm_ext : rf_read(rt);
          state <= (op == 4'hF) ? S_HALT : S_EXE;
        end
        S_EXE: begin
          res_q <= alu_res;
          flg_q <= {alu_c, alu_v, alu_res[MSB], (alu_res == '0)};
          state <= S_WB;
        end
        S_WB: begin
          if (wb_legal) begin
            if (rd != 4'd0 && {1'b0, rd} < NREG) rf[rd] <= res_q;
            stat <= flg_q;
          end
          if (bad_instr) illegal <= 1'b1;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_core_mc.sv
// Scoreboard bench for sisc_core_mc at DATA_W=16: stimulus queues expected
// retire results, a monitor pops them on every done pulse.
module tb_sisc_core_mc;

  logic        clk = 1'b0;
  logic        rst_f;
  logic [31:0] instr;
  logic        instr_vld;
  logic        instr_rdy;
  logic        done;
  logic        halted;
  logic        illegal;
  logic [3:0]  stat;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  logic [3:0]  scan_addr = 4'd0;
  logic [3:0]  mon_addr  = 4'd0;
  logic        scan_mode = 1'b0;
  assign dbg_addr = scan_mode ? scan_addr : mon_addr;

  sisc_core_mc #(.DATA_W(16), .NUM_REGS(16)) dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .instr     (instr),
    .instr_vld (instr_vld),
    .instr_rdy (instr_rdy),
    .done      (done),
    .halted    (halted),
    .illegal   (illegal),
    .stat      (stat),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] val;
    logic [3:0]  st;
    logic        ill;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] fn,
                                      input logic [3:0] rd, input logic [3:0] rs,
                                      input logic [15:0] lo);
    return {op, fn, rd, rs, lo};
  endfunction

  // Waits for instr_rdy, performs one handshake and optionally queues the expected retire.
  task automatic issue(input logic [31:0] w, input bit track, input logic [3:0] rd,
                       input logic [15:0] val, input logic [3:0] st, input logic ill);
    int   t = 0;
    exp_t e;
    @(negedge clk);
    while (!instr_rdy && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!instr_rdy) check("rdy_timeout", 32'(instr_rdy), 32'd1);
    instr     = w;
    instr_vld = 1'b1;
    @(posedge clk);
    #1;
    instr_vld = 1'b0;
    if (track) begin
      e.rd       = rd;
      e.val      = val;
      e.st       = st;
      e.ill      = ill;
      e.done_cyc = cyc + 3;
      sb.push_back(e);
    end
  endtask

  task automatic scan(input logic [3:0] r, input logic [15:0] v);
    scan_mode = 1'b1;
    scan_addr = r;
    #1;
    check($sformatf("scan_r%0d", r), 32'(dbg_data), 32'(v));
    scan_mode = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    check("drain", sb.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          mon_addr = e.rd;
          #1;
          check("done_cyc", 32'(cyc), 32'(e.done_cyc));
          check($sformatf("r%0d", e.rd), 32'(dbg_data), 32'(e.val));
          check("stat", 32'(stat), 32'(e.st));
          check("illegal", 32'(illegal), 32'(e.ill));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_f     = 1'b1;
    instr     = '0;
    instr_vld = 1'b0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rdy_in_reset", 32'(instr_rdy), 32'd0);
    rst_f = 1'b0;
    #1;
    check("rdy_after_reset", 32'(instr_rdy), 32'd1);
    check("halted_reset", 32'(halted), 32'd0);
    check("illegal_reset", 32'(illegal), 32'd0);
    check("stat_reset", 32'(stat), 32'd0);
    check("done_reset", 32'(done), 32'd0);
    for (int r = 0; r < 16; r++) scan(4'(r), 16'h0000);

    // Arithmetic, logic and shift/rotate sequence.
    issue(enc(4'h2, 4'd0, 4'd1, 4'd0, 16'h7FFF), 1, 4'd1,  16'h7FFF, 4'b0000, 1'b0);
    issue(enc(4'h1, 4'd0, 4'd2, 4'd1, 16'h1000), 1, 4'd2,  16'hFFFE, 4'b0110, 1'b0);
    issue(enc(4'h1, 4'd1, 4'd3, 4'd1, 16'h1000), 1, 4'd3,  16'h0000, 4'b1001, 1'b0);
    issue(enc(4'h2, 4'd0, 4'd5, 4'd0, 16'h0003), 1, 4'd5,  16'h0003, 4'b0000, 1'b0);
    issue(enc(4'h2, 4'd7, 4'd4, 4'd5, 16'h0001), 1, 4'd4,  16'h0001, 4'b1000, 1'b0);
    issue(enc(4'h2, 4'd0, 4'd6, 4'd0, 16'h8001), 1, 4'd6,  16'h8001, 4'b0010, 1'b0);
    issue(enc(4'h2, 4'd8, 4'd7, 4'd6, 16'h0001), 1, 4'd7,  16'h0003, 4'b0000, 1'b0);
    issue(enc(4'h1, 4'd6, 4'd8, 4'd2, 16'h5000), 1, 4'd8,  16'hFFF0, 4'b1010, 1'b0);
    issue(enc(4'h2, 4'd9, 4'd9, 4'd6, 16'h0004), 1, 4'd9,  16'h1800, 4'b0000, 1'b0);
    // Write to R0 is dropped but flags still update.
    issue(enc(4'h1, 4'd1, 4'd0, 4'd2, 16'h1000), 1, 4'd0,  16'h0000, 4'b1100, 1'b0);
    // Illegal opcode and illegal function: no write, no flag change, sticky flag.
    issue(enc(4'h5, 4'd0, 4'd1, 4'd0, 16'h0000), 1, 4'd1,  16'h7FFF, 4'b1100, 1'b1);
    issue(enc(4'h1, 4'd12, 4'd2, 4'd1, 16'h1000), 1, 4'd2, 16'hFFFE, 4'b1100, 1'b1);
    issue(enc(4'h1, 4'd4, 4'd10, 4'd2, 16'h1000), 1, 4'd10, 16'h8001, 4'b0010, 1'b1);
    issue(enc(4'h1, 4'd5, 4'd11, 4'd5, 16'h0000), 1, 4'd11, 16'hFFFC, 4'b0010, 1'b1);
    issue(enc(4'h2, 4'd3, 4'd12, 4'd5, 16'h00F0), 1, 4'd12, 16'h00F3, 4'b0000, 1'b1);
    issue(enc(4'h0, 4'd0, 4'd9, 4'd0, 16'h0000), 1, 4'd9,  16'h1800, 4'b0000, 1'b1);
    drain();

    // HALT with a pending request held valid.
    issue(enc(4'hF, 4'd0, 4'd0, 4'd0, 16'h0000), 0, 4'd0, 16'h0, 4'b0, 1'b0);
    instr     = enc(4'h2, 4'd0, 4'd13, 4'd0, 16'h0001);
    instr_vld = 1'b1;
    repeat (4) @(negedge clk);
    check("halted", 32'(halted), 32'd1);
    check("rdy_halted", 32'(instr_rdy), 32'd0);
    repeat (8) @(negedge clk);
    check("halted_hold", 32'(halted), 32'd1);
    scan(4'd13, 16'h0000);
    scan(4'd1, 16'h7FFF);
    instr_vld = 1'b0;

    // Reset leaves HALT and clears all architectural state.
    @(negedge clk);
    rst_f = 1'b1;
    #1;
    check("rdy_rst_hi", 32'(instr_rdy), 32'd0);
    repeat (2) @(negedge clk);
    rst_f = 1'b0;
    #1;
    check("halted_cleared", 32'(halted), 32'd0);
    check("illegal_cleared", 32'(illegal), 32'd0);
    check("stat_cleared", 32'(stat), 32'd0);
    check("rdy_after_halt_rst", 32'(instr_rdy), 32'd1);
    scan(4'd1, 16'h0000);
    scan(4'd2, 16'h0000);

    // Reset during EXE discards the in-flight ADD.
    issue(enc(4'h2, 4'd0, 4'd4, 4'd0, 16'h0005), 0, 4'd0, 16'h0, 4'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_f = 1'b1;
    @(posedge clk);
    #1;
    rst_f = 1'b0;
    #1;
    check("rdy_post_abort", 32'(instr_rdy), 32'd1);
    check("done_post_abort", 32'(done), 32'd0);
    repeat (6) @(negedge clk);
    scan(4'd4, 16'h0000);
    check("stat_post_abort", 32'(stat), 32'd0);

    // Core recovers and executes normally.
    issue(enc(4'h2, 4'd0, 4'd4, 4'd0, 16'h0005), 1, 4'd4, 16'h0005, 4'b0000, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
